// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline-hazard constants: Tuse/Tnew encodings and md-unit latencies.
package hazard_stall_ctrl_pkg;

    localparam logic [1:0] TUSE_NONE = 2'b11;

    localparam int unsigned MULT_LAT = 5;
    localparam int unsigned DIV_LAT  = 10;

    typedef enum logic [1:0] {
        TNEW_0 = 2'd0,
        TNEW_1 = 2'd1,
        TNEW_2 = 2'd2
    } tnew_e;

    // Tnew one stage later: one cycle closer to ready, never below zero.
    function automatic logic [1:0] tnew_step(input logic [1:0] tnew);
        return (tnew == TNEW_0) ? TNEW_0 : tnew - 2'd1;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// Multiply/divide unit scheduler: busy counter loaded when an md op starts in E.
module md_busy_counter #(
    parameter int unsigned MULT_LAT = hazard_stall_ctrl_pkg::MULT_LAT,
    parameter int unsigned DIV_LAT  = hazard_stall_ctrl_pkg::DIV_LAT,
    parameter int unsigned CNT_W    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic IntReq,
    input  logic E_md_start,
    input  logic E_md_div,
    output logic md_busy
);
    import hazard_stall_ctrl_pkg::*;

    logic [CNT_W-1:0] md_cnt;
    logic             md_go;

    assign md_go = E_md_start & ~IntReq;

    // IntReq does not abort a running op; HI/LO are already committed.
    always_ff @(posedge clk) begin
        if (reset)
            md_cnt <= '0;
        else if (md_go)
            md_cnt <= E_md_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
        else if (md_cnt != '0)
            md_cnt <= md_cnt - 1'b1;
    end

    assign md_busy = ~reset & ((md_cnt != '0) | md_go);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/scheduling controller for the 5-stage pipeline (F/D hold, D/E bubble, md scheduling).
// Optional stall-cycle performance counter enabled by HAZ_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int unsigned MULT_LAT = hazard_stall_ctrl_pkg::MULT_LAT,
    parameter int unsigned DIV_LAT  = hazard_stall_ctrl_pkg::DIV_LAT,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IntReq,
    input  logic [4:0]  D_rs,
    input  logic [4:0]  D_rt,
    input  logic [1:0]  D_Tuse_rs,
    input  logic [1:0]  D_Tuse_rt,
    input  logic        D_md,
    input  logic [4:0]  E_A3,
    input  logic [1:0]  E_Tnew,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        stall,
    output logic        F_en,
    output logic        FD_en,
    output logic        DE_clr,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);
    import hazard_stall_ctrl_pkg::*;

    logic [4:0] M_A3;
    logic [1:0] M_Tnew;
    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;

    // A D/E bubble already arrives as E_A3=0/E_Tnew=0, so no special case here.
    always_ff @(posedge clk) begin
        if (reset | IntReq) begin
            M_A3   <= '0;
            M_Tnew <= TNEW_0;
        end else begin
            M_A3   <= E_A3;
            M_Tnew <= tnew_step(E_Tnew);
        end
    end

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) u_md_busy_counter (
        .clk        (clk),
        .reset      (reset),
        .IntReq     (IntReq),
        .E_md_start (E_md_start),
        .E_md_div   (E_md_div),
        .md_busy    (md_busy)
    );

    always_comb begin
        stall_rs = (D_rs != '0) &
                   (((D_rs == E_A3) & (D_Tuse_rs < E_Tnew)) |
                    ((D_rs == M_A3) & (D_Tuse_rs < M_Tnew)));
        stall_rt = (D_rt != '0) &
                   (((D_rt == E_A3) & (D_Tuse_rt < E_Tnew)) |
                    ((D_rt == M_A3) & (D_Tuse_rt < M_Tnew)));
        stall_md = D_md & md_busy;
        stall    = ~reset & ~IntReq & (stall_rs | stall_rt | stall_md);
        F_en     = ~stall;
        FD_en    = ~stall;
        DE_clr   = stall;
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt_q <= '0;
        else if (stall)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Stall/scheduling controller for the 5-stage MIPS pipeline.
- Compares D-stage operand Tuse against the Tnew of the producers in E and M, and holds F/D on a hazard.
- Inserts a bubble into the D/E pipeline register through DE_clr.
- Schedules the shared multiply/divide unit with a busy counter; any md-class instruction in D stalls while the unit is busy.
- Sits beside the D/E register; E_A3 and E_Tnew come straight from that register.

Parameters:
- MULT_LAT, 5, busy cycles after a mult/multu starts in E.
- DIV_LAT, 10, busy cycles after a div/divu starts in E.
- CNT_W, 4, md busy-counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- IntReq  in  1  exception/interrupt taken this cycle; pipeline flushing
- D_rs  in  5  rs field of instruction in D
- D_rt  in  5  rt field of instruction in D
- D_Tuse_rs  in  2  cycles until rs is needed; 2'b11 = not read
- D_Tuse_rt  in  2  cycles until rt is needed; 2'b11 = not read
- D_md  in  1  D holds mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- E_A3  in  5  destination register of instruction in E
- E_Tnew  in  2  Tnew of instruction in E
- E_md_start  in  1  E holds mult/multu/div/divu this cycle
- E_md_div  in  1  with E_md_start: 1 = div/divu, 0 = mult/multu
- stall  out  1  hazard detected this cycle
- F_en  out  1  PC write enable
- FD_en  out  1  F/D register enable
- DE_clr  out  1  bubble into D/E register
- md_busy  out  1  multiply/divide unit busy
- stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- **M-stage tracker registers**, updated every posedge:
  - M_A3 <= (reset|IntReq) ? 0 : E_A3.
  - M_Tnew <= (reset|IntReq) ? 0 : (E_Tnew==0 ? 0 : E_Tnew-1). Saturates at 0.
  - A bubble (DE_clr) already arrives as E_A3=0/E_Tnew=0, so no special case is needed.
- **Register hazard**:
  - stall_rs = (D_rs!=0) & ((D_rs==E_A3 & D_Tuse_rs<E_Tnew) | (D_rs==M_A3 & D_Tuse_rs<M_Tnew)).
  - stall_rt is the same form using D_rt and D_Tuse_rt.
  - Tuse=3 never stalls, because Tnew ≤ 2.
- **md counter md_cnt**:
  - Resets to 0.
  - On E_md_start & ~IntReq: loads (E_md_div ? DIV_LAT : MULT_LAT) - 1.
  - Otherwise: if nonzero, decrements by 1.
  - E_md_start has priority over the decrement.
  - IntReq does not cancel a running operation: the count continues, because the unit's HI/LO are already committed.
- md_busy = md_cnt!=0 | (E_md_start & ~IntReq).
- stall_md = D_md & md_busy.
- **Stall and enables**:
  - stall = ~reset & ~IntReq & (stall_rs | stall_rt | stall_md).
  - F_en = ~stall, FD_en = ~stall, DE_clr = stall.
- **Reset**:
  - Outputs during reset: stall=0, F_en=1, FD_en=1, DE_clr=0, md_busy=0.
  - First cycle after reset: same values as during reset.
- **Simultaneous events**:
  - IntReq with a hazard: stall=0 so the handler fetch proceeds.
  - E_md_start with D_md: stall.
- Reset mid-divide clears md_cnt the same cycle.
- All hazard outputs are combinational from registered state plus inputs, with zero latency.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- **Defined**: stall_cnt is a 32-bit counter.
  - Resets to 0.
  - Increments on every cycle with stall=1.
  - Wraps from 0xFFFFFFFF to 0.
  - Not affected by IntReq.
- **Undefined**: stall_cnt tied to 32'b0; no counter flops.

Decomposition:
- Shared constants file (existing constants style): TUSE_NONE=2'b11, MULT_LAT, DIV_LAT, and the Tnew encodings 0/1/2.
- One natural sub-module: md_busy_counter (md_cnt, md_busy).
- The hazard comparators and M tracker stay in the top module.

Test Plan:
- lw $1 in E (E_A3=1, E_Tnew=2), D_rs=1, D_Tuse_rs=1 → stall=1, DE_clr=1, F_en=0. Next cycle (M_Tnew=1, E bubble) → stall=0.
- addi $2 in E (E_Tnew=1), D_rt=2, D_Tuse_rt=0 → stall=1. Next cycle M_Tnew=0 → stall=0. D_rt=0 with E_A3=0 → stall=0.
- E_md_start=1, E_md_div=0, then D_md=1 held → md_busy high exactly 5 cycles, stall high for those 5 cycles, then 0.
- div start, IntReq asserted at cycle 3 with D_md=1 → stall=0 during IntReq; md_busy remains high through cycle 10.
- reset asserted mid-divide (md_cnt=6) → md_cnt=0, md_busy=0, M_A3=0 next cycle; stall=0 while reset is high.
- HAZ_PERF_CNT_EN defined: 3 stall cycles after reset → stall_cnt=3. Preload 0xFFFFFFFF + 1 stall → stall_cnt=0.
